// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave interface.
// The frame FSM encoding lives here so sibling blocks can decode it.
package spi_slave_pkg;

  localparam int DEFAULT_DATA_W      = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Mode 0: SCLK idles low, data sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin with registered
// single-cycle rise/fall pulses taken from the last synchronizer stage.
module sync_edge_det
  import spi_slave_pkg::*;
#(
  parameter int   STAGES    = DEFAULT_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              dly_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{RESET_VAL}};
      dly_q   <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
      dly_q   <= chain_q[STAGES-1];
      rise_q  <= chain_q[STAGES-1] & ~dly_q;
      fall_q  <= ~chain_q[STAGES-1] & dly_q;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: oversamples SCLK/CS_N/MOSI on clk, receives one
// DATA_W-bit frame per CS window and returns the held status word on MISO.
//
// state | meaning
// IDLE  | no frame; MISO tristated; waits for an armed CS_N fall
// SHIFT | frame in progress; sample MOSI on SCLK rise, shift MISO on fall
// DONE  | all bits received; extra SCLK edges ignored until CS_N rises
module spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int               CNT_W       = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam logic [2:0]       SETTLE_INIT = 3'(SYNC_STAGES + 1);
  localparam logic             SAMPLE_FALL = SPI_CPOL ^ SPI_CPHA;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic cs_sync, cs_rise, cs_fall;
  logic sample_edge, shift_edge;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_sync;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk_in),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (cs_n_in),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
  end

  assign mosi_sync   = mosi_sync_q[SYNC_STAGES-1];
  assign sample_edge = SAMPLE_FALL ? sclk_fall : sclk_rise;
  assign shift_edge  = SAMPLE_FALL ? sclk_rise : sclk_fall;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              armed_q, armed_d;
  logic [2:0]        settle_q, settle_d;
  logic [DATA_W-1:0] rx_word, start_word;
  logic              settle_done, complete;

  // The synchronizers come out of reset showing CS_N high regardless of the
  // pin; arming waits until they have flushed so a low pin cannot fake a fall.
  assign settle_done = (settle_q == 3'd0);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_hold_d   = tx_load ? tx_data : tx_hold_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    armed_d     = armed_q | (settle_done & cs_sync);
    settle_d    = settle_done ? settle_q : settle_q - 3'd1;
    rx_word     = {rx_shift_q[DATA_W-2:0], mosi_sync};
    start_word  = tx_load ? tx_data : tx_hold_q;
    complete    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d    = S_SHIFT;
          tx_shift_d = start_word;
          bit_cnt_d  = '0;
          miso_d     = start_word[DATA_W-1];
          oe_d       = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (sample_edge) begin
          rx_shift_d = rx_word;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            complete   = 1'b1;
            state_d    = S_DONE;
          end
        end
        if (shift_edge) begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          miso_d     = tx_shift_q[DATA_W-2];
        end
        // A final bit arriving with CS_N release still completes the frame.
        if (cs_rise) begin
          state_d     = S_IDLE;
          frame_err_d = !complete && (bit_cnt_d != '0);
        end
      end
      S_DONE: begin
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cs_rise) begin
      oe_d   = 1'b0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_hold_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
      settle_q    <= SETTLE_INIT;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      armed_q     <= armed_d;
      settle_q    <= settle_d;
    end
  end

  assign miso_out  = miso_q;
  assign miso_oe   = oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: an SPI master model drives frames at
// clk/10 while a monitor pops expected words as rx_valid strobes arrive.
module tb_spi_slave_if;

  localparam int DATA_W = 16;
  localparam int HALF   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              sclk_in, cs_n_in, mosi_in, tx_load;
  logic [DATA_W-1:0] tx_data;
  logic              miso_out, miso_oe, rx_valid, frame_err, busy;
  logic [DATA_W-1:0] rx_data;

  spi_slave_if #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .cs_n_in   (cs_n_in),
    .mosi_in   (mosi_in),
    .miso_out  (miso_out),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int rxv_cycles = 0, ferr_cycles = 0, exp_rxv = 0, exp_ferr = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_w;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cycles++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL rx_unexpected got=%h expected=none", rx_data);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        checks++;
        assert (rx_data === exp_w) else begin
          failures++;
          $error("FAIL rx_data got=%h expected=%h", rx_data, exp_w);
        end
      end
    end
    if (frame_err) ferr_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    cs_n_in = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Sends word[n-1:0] MSB first; MISO is sampled just before each rising edge.
  task automatic send_bits(input logic [31:0] word, input int n,
                           output logic [31:0] miso_w, output logic oe_all);
    miso_w = '0;
    oe_all = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      mosi_in = word[i];
      repeat (HALF) @(negedge clk);
      miso_w  = {miso_w[30:0], miso_out};
      oe_all  = oe_all & miso_oe;
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] word, input int n,
                       output logic [31:0] miso_w, output logic oe_all);
    cs_low();
    send_bits(word, n, miso_w, oe_all);
    cs_high();
  endtask

  task automatic load_tx(input logic [DATA_W-1:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  logic [31:0] miso_w;
  logic        oe_all;

  initial begin
    rst = 1'b1; sclk_in = 1'b0; cs_n_in = 1'b1; mosi_in = 1'b0;
    tx_load = 1'b0; tx_data = '0;
    repeat (4) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_miso_oe", 32'(miso_oe), 32'h0);
    check("rst_miso_out", 32'(miso_out), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Basic frame with a preloaded status word
    load_tx(16'hA55A);
    exp_q.push_back(16'h1234); exp_rxv++;
    cs_low();
    check("busy_active", 32'(busy), 32'h1);
    send_bits(32'h1234, 16, miso_w, oe_all);
    cs_high();
    check("t1_miso", miso_w, 32'hA55A);
    check("t1_oe_in_frame", 32'(oe_all), 32'h1);
    check("t1_oe_after", 32'(miso_oe), 32'h0);
    check("t1_busy_after", 32'(busy), 32'h0);
    check("t1_rxv_count", rxv_cycles, exp_rxv);

    // Aborted frame after 7 bits
    frame(32'h55, 7, miso_w, oe_all);
    exp_ferr++;
    check("t2_ferr_count", ferr_cycles, exp_ferr);
    check("t2_rx_hold", 32'(rx_data), 32'h1234);
    check("t2_rxv_count", rxv_cycles, exp_rxv);

    exp_q.push_back(16'hBEEF); exp_rxv++;
    frame(32'hBEEF, 16, miso_w, oe_all);
    check("t3_rxv_count", rxv_cycles, exp_rxv);

    // Back-to-back frames with a status reload between them
    exp_q.push_back(16'h00FF); exp_rxv++;
    frame(32'h00FF, 16, miso_w, oe_all);
    check("t4a_miso", miso_w, 32'hA55A);
    load_tx(16'h0001);
    exp_q.push_back(16'hFF00); exp_rxv++;
    frame(32'hFF00, 16, miso_w, oe_all);
    check("t4b_miso", miso_w, 32'h0001);
    check("t4_rxv_count", rxv_cycles, exp_rxv);

    // 20 SCLK pulses in one CS window
    exp_q.push_back(16'hC3C3); exp_rxv++;
    frame(32'hC3C3A, 20, miso_w, oe_all);
    check("t5_rxv_count", rxv_cycles, exp_rxv);
    check("t5_ferr_count", ferr_cycles, exp_ferr);

    // CS_N release coincident with the final SCLK rise
    exp_q.push_back(16'h6DB6); exp_rxv++;
    cs_low();
    send_bits(32'h36DB, 15, miso_w, oe_all);
    mosi_in = 1'b0;
    repeat (HALF) @(negedge clk);
    sclk_in = 1'b1;
    cs_n_in = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk_in = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_rxv_count", rxv_cycles, exp_rxv);
    check("t6_ferr_count", ferr_cycles, exp_ferr);
    check("t6_oe_after", 32'(miso_oe), 32'h0);

    // Reset in the middle of a frame while CS_N stays low
    cs_low();
    send_bits(32'h138, 9, miso_w, oe_all);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t7_busy_rst", 32'(busy), 32'h0);
    check("t7_oe_rst", 32'(miso_oe), 32'h0);
    check("t7_rx_rst", 32'(rx_data), 32'h0);
    send_bits(32'h3A, 7, miso_w, oe_all);
    cs_high();
    check("t7_rxv_count", rxv_cycles, exp_rxv);
    check("t7_ferr_count", ferr_cycles, exp_ferr);
    exp_q.push_back(16'h5A5A); exp_rxv++;
    frame(32'h5A5A, 16, miso_w, oe_all);
    check("t7_rxv_after", rxv_cycles, exp_rxv);

    // Status word loaded in the same cycle the CS_N fall is detected
    load_tx(16'h0001);
    @(negedge clk);
    tx_data = 16'h7E81;
    exp_q.push_back(16'h0F0F); exp_rxv++;
    @(negedge clk);
    cs_n_in = 1'b0;
    repeat (3) @(negedge clk);
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(32'h0F0F, 16, miso_w, oe_all);
    cs_high();
    check("t8_bypass_miso", miso_w, 32'h7E81);

    repeat (10) @(negedge clk);
    check("end_queue_empty", exp_q.size(), 0);
    check("end_rxv_count", rxv_cycles, exp_rxv);
    check("end_ferr_count", ferr_cycles, exp_ferr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
